pio_input_irq: RTL

//  Parametrised Avalon-MM slave input port: N-bit external input, synchronised, with per-bit

---
 rtl/pio_pkg.sv | 37 +++
 rtl/pio_sync_bus.sv | 31 +++
 rtl/pio_input_irq.sv | 111 +++++++++++
 3 files changed

// File: rtl/pio_pkg.sv
// Shared definitions for the PIO input/interrupt block.
// Holds the word register map, the edge/irq mode encodings and the
// edge-detect helper used by pio_input_irq.
package pio_pkg;

    // Word address map of the Avalon-MM slave
    typedef enum logic [1:0] {
        ADDR_DATA = 2'd0,
        ADDR_RSVD = 2'd1,
        ADDR_MASK = 2'd2,
        ADDR_EDGE = 2'd3
    } pio_addr_e;

    // EDGE_TYPE parameter values
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // IRQ_MODE parameter values
    localparam int IRQ_LEVEL = 0;
    localparam int IRQ_EDGE  = 1;

    // Per-bit edge detect on a 32-bit view; callers truncate to their width.
    function automatic logic [31:0] detect_edges(input int edge_type,
                                                 input logic [31:0] cur,
                                                 input logic [31:0] prev);
        logic [31:0] det;
        det = '0;
        case (edge_type)
            EDGE_RISE: det = cur & ~prev;
            EDGE_FALL: det = ~cur & prev;
            default:   det = cur ^ prev;
        endcase
        return det;
    endfunction

endpackage

// File: rtl/pio_sync_bus.sv
// Multi-bit synchroniser: every bit of d passes through SYNC_STAGES flops
// before appearing on q. Plain flop chain, asynchronous active-high reset to 0.
// Ports:
//   clk    in  1      system clock
//   reset  in  1      asynchronous, active-high reset
//   d      in  WIDTH  asynchronous input bus
//   q      out WIDTH  synchronised output (last stage)
module pio_sync_bus #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Stage 0 is the capture flop; stage SYNC_STAGES-1 feeds q
    logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/pio_input_irq.sv
// Avalon-MM input PIO with per-bit edge capture and maskable interrupt.
// External inputs are synchronised, edge-detected against the previous
// synchronised value, and latched into W1C capture bits. readdata is
// registered every clock from the addressed register (no read strobe).
// Ports:
//   clk        in  1      system clock
//   reset      in  1      asynchronous, active-high reset
//   address    in  2      word register select (DATA/RSVD/MASK/EDGE)
//   write      in  1      single-cycle write strobe
//   writedata  in  32     write data
//   in_port    in  WIDTH  asynchronous external inputs
//   readdata   out 32     registered read data, zero-extended
//   irq        out 1      registered interrupt request, active-high
module pio_input_irq
    import pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE,
    parameter int IRQ_MODE    = IRQ_EDGE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             write,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("pio_input_irq: WIDTH must be 1..32");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
        $error("pio_input_irq: SYNC_STAGES must be 2..4");
    end

    pio_addr_e        addr_sel;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] edge_q;
    logic [WIDTH-1:0] det;
    logic [WIDTH-1:0] wdata;
    logic             wr_mask;
    logic             wr_edge;
    logic [31:0]      rd_next;
    logic             irq_next;
    logic             unused_wd;

    assign addr_sel  = pio_addr_e'(address);
    assign wdata     = writedata[WIDTH-1:0];
    // Bits above WIDTH are intentionally discarded on write
    assign unused_wd = ^writedata;
    assign wr_mask   = write && (addr_sel == ADDR_MASK);
    assign wr_edge   = write && (addr_sel == ADDR_EDGE);

    pio_sync_bus #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (in_port),
        .q     (sync_q)
    );

    always_comb begin
        det = WIDTH'(detect_edges(EDGE_TYPE, 32'(sync_q), 32'(prev_q)));
    end

    // Mux samples register state before this clock's write lands
    always_comb begin
        rd_next = '0;
        case (addr_sel)
            ADDR_DATA: rd_next[WIDTH-1:0] = sync_q;
            ADDR_MASK: rd_next[WIDTH-1:0] = mask_q;
            ADDR_EDGE: rd_next[WIDTH-1:0] = edge_q;
            default:   rd_next = '0;
        endcase
    end

    always_comb begin
        if (IRQ_MODE == IRQ_LEVEL) begin
            irq_next = |(sync_q & mask_q);
        end else begin
            irq_next = |(edge_q & mask_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q   <= '0;
            mask_q   <= '0;
            edge_q   <= '0;
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            prev_q   <= sync_q;
            if (wr_mask) begin
                mask_q <= wdata;
            end
            // A fresh edge wins over a same-cycle W1C of that bit
            edge_q   <= det | (edge_q & ~({WIDTH{wr_edge}} & wdata));
            readdata <= rd_next;
            irq      <= irq_next;
        end
    end

endmodule
